// File: rtl/neuron_buffer_controller_if.sv
// Handshake and sequencing bundle between the layer controller/buffer swapper and neuron_buffer_controller.
// NBC_IO_ARB_EN adds the host IO arbitration signals.
interface neuron_buffer_controller_if #(
    parameter int A = 7
);
    logic           start;
    logic [3:0]     numLayers;
    logic [A-1:0]   numReads;
    logic [15:0]    poolMask;
    logic           stall;
    logic           readBufferSelect;
    logic           doPooling;
    logic [A-1:0]   readBuffAddress;
    logic [A-1:0]   writeBuffAddress;
    logic           nRWrite;
    logic           nWWrite;
    logic [3:0]     layerIdx;
    logic           busy;
    logic           done;
`ifdef NBC_IO_ARB_EN
    logic           ioReq;
    logic           ioWrite;
    logic [A-1:0]   ioAddr;
    logic           ioGnt;

    modport master (
        output start, numLayers, numReads, poolMask, stall, ioReq, ioWrite, ioAddr,
        input  readBufferSelect, doPooling, readBuffAddress, writeBuffAddress,
               nRWrite, nWWrite, layerIdx, busy, done, ioGnt
    );
    modport slave (
        input  start, numLayers, numReads, poolMask, stall, ioReq, ioWrite, ioAddr,
        output readBufferSelect, doPooling, readBuffAddress, writeBuffAddress,
               nRWrite, nWWrite, layerIdx, busy, done, ioGnt
    );
`else
    modport master (
        output start, numLayers, numReads, poolMask, stall,
        input  readBufferSelect, doPooling, readBuffAddress, writeBuffAddress,
               nRWrite, nWWrite, layerIdx, busy, done
    );
    modport slave (
        input  start, numLayers, numReads, poolMask, stall,
        output readBufferSelect, doPooling, readBuffAddress, writeBuffAddress,
               nRWrite, nWWrite, layerIdx, busy, done
    );
`endif
endinterface

// File: rtl/neuron_buffer_controller.sv
// Ping-pong neuron buffer sequencer: per-layer read walk, LAT-delayed write strobes, buffer swap.
// Optional host IO arbitration in IDLE is enabled by defining NBC_IO_ARB_EN.
module neuron_buffer_controller #(
    parameter int A   = 7,
    parameter int LAT = 3
) (
    input logic                        clk,
    input logic                        reset,
    neuron_buffer_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, SWAP, DONE} state_t;

    state_t         state_reg;
    logic [3:0]     num_layers_reg;
    logic [3:0]     layer_reg;
    logic [A-1:0]   num_reads_reg;
    logic [A-1:0]   rd_addr_reg;
    logic [A-1:0]   wr_addr_reg;
    logic [15:0]    pool_mask_reg;
    logic [LAT-1:0] valid_reg;
    logic [LAT-1:0] valid_next;
    logic           sel_reg;
    logic           pool_reg;
    logic           busy_reg;
    logic           done_reg;

    logic           advance;
    logic           write_fire;
    logic           last_read;
    logic           start_ok;
    logic [3:0]     layer_next;

    genvar gi;

    // Valid pipe: stage 0 takes a 1 for every issued read, the last stage marks a returning word.
    assign valid_next[0] = (state_reg == READ);
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_pipe
            assign valid_next[gi] = valid_reg[gi-1];
        end
    endgenerate

    assign advance    = ((state_reg == READ) || (state_reg == DRAIN)) && !bus.stall;
    // Gated by the live stall so a stalled cycle holds the word instead of writing it twice.
    assign write_fire = valid_reg[LAT-1] && !bus.stall;
    assign last_read  = (rd_addr_reg == num_reads_reg - A'(1));
    assign layer_next = layer_reg + 4'd1;

`ifdef NBC_IO_ARB_EN
    logic gnt_reg;

    assign start_ok             = bus.start && !bus.ioReq && !gnt_reg;
    assign bus.ioGnt            = gnt_reg;
    assign bus.readBuffAddress  = gnt_reg ? bus.ioAddr : rd_addr_reg;
    assign bus.nRWrite          = gnt_reg && bus.ioWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_reg <= 1'b0;
        end else begin
            gnt_reg <= (state_reg == IDLE) && bus.ioReq;
        end
    end
`else
    assign start_ok             = bus.start;
    assign bus.readBuffAddress  = rd_addr_reg;
    assign bus.nRWrite          = 1'b0;
`endif

    assign bus.writeBuffAddress = wr_addr_reg;
    assign bus.nWWrite          = write_fire;
    assign bus.readBufferSelect = sel_reg;
    assign bus.doPooling        = pool_reg;
    assign bus.layerIdx         = layer_reg;
    assign bus.busy             = busy_reg;
    assign bus.done             = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            num_layers_reg <= '0;
            num_reads_reg  <= '0;
            pool_mask_reg  <= '0;
            layer_reg      <= '0;
            rd_addr_reg    <= '0;
            wr_addr_reg    <= '0;
            valid_reg      <= '0;
            sel_reg        <= 1'b0;
            pool_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (advance) begin
                valid_reg <= valid_next;
            end
            if (write_fire) begin
                wr_addr_reg <= wr_addr_reg + A'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        num_layers_reg <= bus.numLayers;
                        num_reads_reg  <= bus.numReads;
                        pool_mask_reg  <= bus.poolMask;
                        layer_reg      <= '0;
                        rd_addr_reg    <= '0;
                        wr_addr_reg    <= '0;
                        sel_reg        <= 1'b0;
                        busy_reg       <= 1'b1;
                        if (bus.numLayers == 4'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            pool_reg  <= 1'b0;
                        end else begin
                            state_reg <= READ;
                            pool_reg  <= bus.poolMask[0];
                        end
                    end
                end
                READ: begin
                    if (!bus.stall) begin
                        rd_addr_reg <= rd_addr_reg + A'(1);
                        if (last_read) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.stall && (valid_next == '0)) begin
                        state_reg <= SWAP;
                    end
                end
                SWAP: begin
                    sel_reg     <= ~sel_reg;
                    rd_addr_reg <= '0;
                    wr_addr_reg <= '0;
                    layer_reg   <= layer_next;
                    if (layer_next == num_layers_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= READ;
                        pool_reg  <= pool_mask_reg[layer_next];
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    pool_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_buffer_controller.sv
// Directed bench for neuron_buffer_controller: cycle tables plus hand sequences for stall, wrap, multi-layer and reset.
module tb_neuron_buffer_controller;
    localparam int A   = 7;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    neuron_buffer_controller_if #(.A(A)) bus ();

    neuron_buffer_controller #(.A(A), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [6:0] rd;
        logic       nww;
        logic [6:0] wr;
        logic       sel;
        logic       busy;
        logic       done;
        logic [3:0] layer;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic st, input int rd, input logic nww, input int wr,
                                input logic sel, input logic busy, input logic dn, input int layer);
        vec_t v;
        v.stall = st; v.rd = 7'(rd); v.nww = nww; v.wr = 7'(wr);
        v.sel = sel; v.busy = busy; v.done = dn; v.layer = 4'(layer);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int nl, input int nr, input int pm);
        bus.numLayers = 4'(nl);
        bus.numReads  = 7'(nr);
        bus.poolMask  = 16'(pm);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic run_rows(input int first, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.stall = tbl[first+i].stall;
            #1;
            chk($sformatf("%s c%0d rd", tag, i+1), int'(bus.readBuffAddress), int'(tbl[first+i].rd));
            chk($sformatf("%s c%0d nww", tag, i+1), int'(bus.nWWrite), int'(tbl[first+i].nww));
            chk($sformatf("%s c%0d wr", tag, i+1), int'(bus.writeBuffAddress), int'(tbl[first+i].wr));
            chk($sformatf("%s c%0d sel", tag, i+1), int'(bus.readBufferSelect), int'(tbl[first+i].sel));
            chk($sformatf("%s c%0d busy", tag, i+1), int'(bus.busy), int'(tbl[first+i].busy));
            chk($sformatf("%s c%0d done", tag, i+1), int'(bus.done), int'(tbl[first+i].done));
            chk($sformatf("%s c%0d layer", tag, i+1), int'(bus.layerIdx), int'(tbl[first+i].layer));
            chk($sformatf("%s c%0d nrw", tag, i+1), int'(bus.nRWrite), 0);
            $display("row %s cycle %0d rd=%0d nww=%0d wr=%0d sel=%0d done=%0d", tag, i+1,
                     bus.readBuffAddress, bus.nWWrite, bus.writeBuffAddress, bus.readBufferSelect, bus.done);
            tick();
        end
        bus.stall = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_wr[$];
        int done_cyc;
        int bad;
        int pool_hi;
        int done_cnt;
        logic [11:0] pat;

        // One layer, 4 reads, no stall
        tbl[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 2, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 3, 1, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 4, 1, 1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 4, 1, 2, 0, 1, 0, 0);
        tbl[6]  = mk(0, 4, 1, 3, 0, 1, 0, 0);
        tbl[7]  = mk(0, 4, 0, 4, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1);
        // One layer, 4 reads, stall at cycles 2 and 3
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 1, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 1, 0, 0);
        tbl[14] = mk(0, 2, 0, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 3, 1, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 4, 1, 1, 0, 1, 0, 0);
        tbl[17] = mk(0, 4, 1, 2, 0, 1, 0, 0);
        tbl[18] = mk(0, 4, 1, 3, 0, 1, 0, 0);
        tbl[19] = mk(0, 4, 0, 4, 0, 1, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 1, 1, 1, 1);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, 1);

        bus.start = 1'b0; bus.stall = 1'b0;
        bus.numLayers = '0; bus.numReads = '0; bus.poolMask = '0;
`ifdef NBC_IO_ARB_EN
        bus.ioReq = 1'b0; bus.ioWrite = 1'b0; bus.ioAddr = '0;
`endif
        reset = 1'b1;
        tick(); tick();
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst rd", int'(bus.readBuffAddress), 0);
        chk("rst wr", int'(bus.writeBuffAddress), 0);
        chk("rst sel", int'(bus.readBufferSelect), 0);
        chk("rst nww", int'(bus.nWWrite), 0);
        chk("rst pool", int'(bus.doPooling), 0);
        chk("rst layer", int'(bus.layerIdx), 0);
        $display("reset state busy=%0d sel=%0d", bus.busy, bus.readBufferSelect);
        reset = 1'b0;
        tick();

        start_run(1, 4, 0);
        run_rows(0, 10, "base");
        start_run(1, 4, 0);
        run_rows(10, 12, "stall2");

        // Three layers, pool only layer 1; a start mid-run must be ignored
        start_run(3, 2, 16'h0002);
        pool_hi = 0; done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            bus.start = (c == 3);
            if (c == 3) begin bus.numLayers = 4'd1; bus.poolMask = 16'hFFFF; end
            #1;
            if (bus.doPooling) pool_hi++;
            if (bus.done) done_cnt++;
            case (c)
                1:  begin chk("ml c1 sel", int'(bus.readBufferSelect), 0); chk("ml c1 pool", int'(bus.doPooling), 0); end
                7:  begin chk("ml c7 sel", int'(bus.readBufferSelect), 1); chk("ml c7 pool", int'(bus.doPooling), 1);
                          chk("ml c7 layer", int'(bus.layerIdx), 1); end
                12: begin chk("ml c12 pool", int'(bus.doPooling), 1); chk("ml c12 layer", int'(bus.layerIdx), 1); end
                13: begin chk("ml c13 sel", int'(bus.readBufferSelect), 0); chk("ml c13 pool", int'(bus.doPooling), 0);
                          chk("ml c13 layer", int'(bus.layerIdx), 2); end
                19: begin chk("ml c19 sel", int'(bus.readBufferSelect), 1); chk("ml c19 done", int'(bus.done), 1);
                          chk("ml c19 layer", int'(bus.layerIdx), 3); end
                20: begin chk("ml c20 busy", int'(bus.busy), 0); chk("ml c20 sel", int'(bus.readBufferSelect), 1);
                          chk("ml c20 pool", int'(bus.doPooling), 0); end
                default: ;
            endcase
            $display("multi cycle %0d layer=%0d sel=%0d pool=%0d done=%0d", c, bus.layerIdx,
                     bus.readBufferSelect, bus.doPooling, bus.done);
            tick();
        end
        chk("ml pool cycles", pool_hi, 6);
        chk("ml done pulses", done_cnt, 1);

        // Zero layers goes straight to DONE
        start_run(0, 4, 0);
        chk("nl0 done", int'(bus.done), 1);
        chk("nl0 busy", int'(bus.busy), 1);
        $display("zero-layer run done=%0d", bus.done);
        tick();
        chk("nl0 idle", int'(bus.busy), 0);

        // Irregular stalls: every write lands once, in order, and the layer stretches by the stall count
        pat = 12'b1001_0100_0110;
        q_wr.delete(); done_cyc = -1;
        start_run(1, 10, 0);
        for (int c = 1; c <= 60; c++) begin
            bus.stall = (c <= 12) ? pat[c-1] : 1'b0;
            #1;
            if (bus.nWWrite) q_wr.push_back(int'(bus.writeBuffAddress));
            if (bus.done) begin done_cyc = c; break; end
            tick();
        end
        bus.stall = 1'b0;
        bad = 0;
        foreach (q_wr[i]) if (q_wr[i] != i) bad++;
        chk("stall writes", q_wr.size(), 10);
        chk("stall addr order", bad, 0);
        chk("stall done cycle", done_cyc, 10 + LAT + 1 + $countones(pat) + 1);
        $display("stall run writes=%0d done_cycle=%0d", q_wr.size(), done_cyc);
        tick(); tick();

        // numReads=0 means 128 words, wrap only at layer end
        q_wr.delete(); done_cyc = -1; bad = 0;
        start_run(1, 0, 0);
        for (int c = 1; c <= 200; c++) begin
            #1;
            if (c <= 128 && int'(bus.readBuffAddress) != c - 1) bad++;
            if (c == 129) chk("wrap rd c129", int'(bus.readBuffAddress), 0);
            if (bus.nWWrite) q_wr.push_back(int'(bus.writeBuffAddress));
            if (bus.done) begin done_cyc = c; break; end
            tick();
        end
        chk("wrap rd seq", bad, 0);
        chk("wrap writes", q_wr.size(), 128);
        bad = 0;
        foreach (q_wr[i]) if (q_wr[i] != i) bad++;
        chk("wrap wr order", bad, 0);
        chk("wrap done cycle", done_cyc, 128 + LAT + 1 + 1);
        $display("wrap run writes=%0d done_cycle=%0d", q_wr.size(), done_cyc);
        tick(); tick();

        // Reset in the DRAIN of layer 1 aborts the run
        start_run(2, 4, 16'h0003);
        for (int c = 1; c < 14; c++) tick();
        chk("pre-rst layer", int'(bus.layerIdx), 1);
        chk("pre-rst nww", int'(bus.nWWrite), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid rst busy", int'(bus.busy), 0);
        chk("mid rst sel", int'(bus.readBufferSelect), 0);
        chk("mid rst nww", int'(bus.nWWrite), 0);
        chk("mid rst layer", int'(bus.layerIdx), 0);
        chk("mid rst rd", int'(bus.readBuffAddress), 0);
        chk("mid rst wr", int'(bus.writeBuffAddress), 0);
        chk("mid rst pool", int'(bus.doPooling), 0);
        $display("mid-drain reset busy=%0d nww=%0d", bus.busy, bus.nWWrite);
        @(negedge clk);
        reset = 1'b0;
        tick();
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.done || bus.busy) done_cnt++;
            tick();
        end
        chk("post rst quiet", done_cnt, 0);
        start_run(1, 4, 0);
        run_rows(0, 10, "rerun");

`ifdef NBC_IO_ARB_EN
        bus.ioReq = 1'b1; bus.ioWrite = 1'b1; bus.ioAddr = 7'd5;
        bus.numLayers = 4'd1; bus.numReads = 7'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("io gnt", int'(bus.ioGnt), 1);
        chk("io busy", int'(bus.busy), 0);
        chk("io rd", int'(bus.readBuffAddress), 5);
        chk("io nrw", int'(bus.nRWrite), 1);
        $display("io grant gnt=%0d rd=%0d nrw=%0d", bus.ioGnt, bus.readBuffAddress, bus.nRWrite);
        bus.ioReq = 1'b0; bus.ioWrite = 1'b0;
        tick();
        chk("io drop", int'(bus.ioGnt), 0);
        chk("io nrw drop", int'(bus.nRWrite), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
